// File: rtl/fir_pkg.sv
// Shared constants, state encoding and lane helpers for the FIR sample buffer.
// Lane slice macro: element idx of width w inside a packed multi-lane vector.
`ifndef FIR_LANE
`define FIR_LANE(vec, idx, w) vec[(w)*(idx) +: (w)]
`endif

package fir_pkg;

   localparam int unsigned SAMPLE_W     = 18;
   localparam int unsigned LANES        = 4;
   localparam int unsigned LANE_W       = 2;
   localparam int unsigned BUF_ADDR_W   = 12;
   localparam int unsigned SAMPLE_IDX_W = BUF_ADDR_W + LANE_W;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_WRITE   = 3'd1;
   localparam logic [2:0] ST_START   = 3'd2;
   localparam logic [2:0] ST_COMPUTE = 3'd3;
   localparam logic [2:0] ST_CLEAR   = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE    = ST_IDLE,
      S_WRITE   = ST_WRITE,
      S_START   = ST_START,
      S_COMPUTE = ST_COMPUTE,
      S_CLEAR   = ST_CLEAR
   } state_t;

   // Bank (or lane) index reached by stepping offset places back from phase.
   function automatic logic [LANE_W-1:0] lane_bank(input logic [LANE_W-1:0] phase,
                                                   input logic [LANE_W-1:0] offset);
      return phase - offset;
   endfunction

endpackage

// File: rtl/fir_buf_rotator.sv
// Rotates four bank read words into one newest-first word using the newest sample's bank.
module fir_buf_rotator
   import fir_pkg::*;
#(
   parameter int unsigned DATA_W = SAMPLE_W
) (
   input  logic [LANE_W-1:0]       phase,
   input  logic [LANES*DATA_W-1:0] bank_words,
   output logic [LANES*DATA_W-1:0] word
);

   // Lane j (0 = newest) sits in the top slot and comes from bank phase-j.
   always_comb begin
      word = '0;
      for (int j = 0; j < LANES; j++) begin
         `FIR_LANE(word, LANES-1-j, DATA_W) =
            `FIR_LANE(bank_words, int'(lane_bank(phase, LANE_W'(j))), DATA_W);
      end
   end

endmodule

// File: rtl/fir_sample_buffer.sv
// Write side of the FIR circular sample buffer plus read-address translation for the FIR pass.
// Build option SAMPLE_BUF_CLEAR_EN adds a post-reset sweep that zeroes all four banks.
module fir_sample_buffer
   import fir_pkg::*;
#(
   parameter int unsigned ADDR_W = BUF_ADDR_W,
   parameter int unsigned DATA_W = SAMPLE_W
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [DATA_W-1:0]       sample_in,
   input  logic                    sample_valid,
   output logic                    datain_ready,
   input  logic                    fir_done,
   input  logic [ADDR_W-1:0]       addr_data,
   output logic [LANES*DATA_W-1:0] datain,
   output logic [LANES-1:0]        bank_we,
   output logic [ADDR_W-1:0]       bank_waddr,
   output logic [DATA_W-1:0]       bank_wdata,
   output logic [LANES*ADDR_W-1:0] bank_raddr,
   input  logic [LANES*DATA_W-1:0] bank_rdata,
   output logic                    busy,
   output logic                    overflow
);

   localparam int unsigned IDX_W = ADDR_W + LANE_W;

   // With the sweep compiled in, reset lands directly in the first sweep cycle.
`ifdef SAMPLE_BUF_CLEAR_EN
   localparam state_t           RST_STATE = S_CLEAR;
   localparam logic [LANES-1:0] RST_WE    = '1;
   localparam logic             RST_BUSY  = 1'b1;
`else
   localparam state_t           RST_STATE = S_IDLE;
   localparam logic [LANES-1:0] RST_WE    = '0;
   localparam logic             RST_BUSY  = 1'b0;
`endif

   state_t              state, state_nxt;
   logic [IDX_W-1:0]    wp, wp_nxt;
   logic [IDX_W-1:0]    n, n_nxt;
   logic                hold_valid, hold_valid_nxt;
   logic [DATA_W-1:0]   hold_data, hold_data_nxt;
   logic [LANE_W-1:0]   phase;

   logic [LANES-1:0]    we_nxt;
   logic [ADDR_W-1:0]   waddr_nxt;
   logic [DATA_W-1:0]   wdata_nxt;
   logic                ready_nxt;
   logic                busy_nxt;
   logic                overflow_nxt;

   // State, pointers, hold entry and all registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= RST_STATE;
         wp           <= '0;
         n            <= '1;
         hold_valid   <= 1'b0;
         hold_data    <= '0;
         phase        <= '0;
         bank_we      <= RST_WE;
         bank_waddr   <= '0;
         bank_wdata   <= '0;
         datain_ready <= 1'b0;
         busy         <= RST_BUSY;
         overflow     <= 1'b0;
      end else begin
         state        <= state_nxt;
         wp           <= wp_nxt;
         n            <= n_nxt;
         hold_valid   <= hold_valid_nxt;
         hold_data    <= hold_data_nxt;
         phase        <= n[LANE_W-1:0];
         bank_we      <= we_nxt;
         bank_waddr   <= waddr_nxt;
         bank_wdata   <= wdata_nxt;
         datain_ready <= ready_nxt;
         busy         <= busy_nxt;
         overflow     <= overflow_nxt;
      end
   end

   // Next state; outputs are computed from the next state so they line up with it.
   always_comb begin
      state_nxt      = state;
      wp_nxt         = wp;
      n_nxt          = n;
      hold_valid_nxt = hold_valid;
      hold_data_nxt  = hold_data;
      we_nxt         = '0;
      waddr_nxt      = bank_waddr;
      wdata_nxt      = bank_wdata;
      ready_nxt      = 1'b0;
      busy_nxt       = 1'b0;
      overflow_nxt   = 1'b0;

      case (state)
         S_IDLE: begin
            if (hold_valid) begin
               wdata_nxt      = hold_data;
               hold_valid_nxt = sample_valid;
               if (sample_valid) begin
                  hold_data_nxt = sample_in;
               end
               state_nxt = S_WRITE;
            end else if (sample_valid) begin
               wdata_nxt = sample_in;
               state_nxt = S_WRITE;
            end
         end
         S_WRITE: begin
            n_nxt     = wp;
            wp_nxt    = wp + IDX_W'(1);
            state_nxt = S_START;
         end
         S_START: begin
            state_nxt = S_COMPUTE;
         end
         S_COMPUTE: begin
            if (fir_done) begin
               state_nxt = S_IDLE;
            end
         end
`ifdef SAMPLE_BUF_CLEAR_EN
         S_CLEAR: begin
            wdata_nxt = '0;
            waddr_nxt = bank_waddr + ADDR_W'(1);
            if (bank_waddr == '1) begin
               state_nxt = S_IDLE;
            end else begin
               we_nxt = '1;
            end
         end
`endif
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      // Samples arriving while busy park in the single hold entry or are dropped.
      if (state != S_IDLE && sample_valid) begin
         if (!hold_valid) begin
            hold_valid_nxt = 1'b1;
            hold_data_nxt  = sample_in;
         end else begin
            overflow_nxt = 1'b1;
         end
      end

      if (state_nxt == S_WRITE) begin
         we_nxt    = LANES'(1) << wp[LANE_W-1:0];
         waddr_nxt = wp[IDX_W-1:LANE_W];
      end

      ready_nxt = (state_nxt == S_START);
      busy_nxt  = (state_nxt != S_IDLE);
   end

   // Bank b holds lane (n - b) of the requested word; its word address is that sample's index / 4.
   always_comb begin
      bank_raddr = '0;
      for (int b = 0; b < LANES; b++) begin
         bank_raddr[ADDR_W*b +: ADDR_W] =
            ADDR_W'((n - {addr_data, LANE_W'(0)}
                       - IDX_W'(lane_bank(n[LANE_W-1:0], LANE_W'(b)))) >> LANE_W);
      end
   end

   fir_buf_rotator #(
      .DATA_W     (DATA_W)
   ) u_rotator (
      .phase      (phase),
      .bank_words (bank_rdata),
      .word       (datain)
   );

endmodule
